// File: rtl/tl_inflight_limiter_pkg.sv
// Shared TileLink opcodes, channel indices and payload classification helpers
// for the in-flight limiter and its burst tracker.
package tl_inflight_limiter_pkg;

    localparam int SizeWidth = 3;

    // Channel slots inside the burst tracker's packed vectors
    localparam int ChA   = 0;
    localparam int ChC   = 1;
    localparam int ChD   = 2;
    localparam int NumCh = 3;

    typedef enum logic [2:0] {
        PutFullData    = 3'd0,
        PutPartialData = 3'd1,
        ArithmeticData = 3'd2,
        LogicalData    = 3'd3,
        Get            = 3'd4,
        Intent         = 3'd5,
        AcquireBlock   = 3'd6,
        AcquirePerm    = 3'd7
    } tl_a_op_e;

    typedef enum logic [2:0] {
        ProbeAck     = 3'd4,
        ProbeAckData = 3'd5,
        Release      = 3'd6,
        ReleaseData  = 3'd7
    } tl_c_op_e;

    typedef enum logic [2:0] {
        AccessAck     = 3'd0,
        AccessAckData = 3'd1,
        HintAck       = 3'd2,
        Grant         = 3'd4,
        GrantData     = 3'd5,
        ReleaseAck    = 3'd6
    } tl_d_op_e;

    function automatic logic a_has_data(tl_a_op_e op);
        return op inside {PutFullData, PutPartialData, ArithmeticData, LogicalData};
    endfunction

    function automatic logic c_has_data(tl_c_op_e op);
        return op inside {ProbeAckData, ReleaseData};
    endfunction

    function automatic logic d_has_data(tl_d_op_e op);
        return op inside {AccessAckData, GrantData};
    endfunction

endpackage

// File: rtl/tl_inflight_limiter_if.sv
// Five-channel TileLink link; master issues A/C/E and receives B/D.
interface tl_inflight_limiter_if #(
    parameter int DataWidth   = 64,
    parameter int AddrWidth   = 56,
    parameter int SourceWidth = 1,
    parameter int SinkWidth   = 1
) ();
    localparam int Sw = tl_inflight_limiter_pkg::SizeWidth;

    logic                                a_valid, a_ready;
    tl_inflight_limiter_pkg::tl_a_op_e   a_opcode;
    logic [2:0]                          a_param;
    logic [Sw-1:0]                       a_size;
    logic [SourceWidth-1:0]              a_source;
    logic [AddrWidth-1:0]                a_address;
    logic [DataWidth/8-1:0]              a_mask;
    logic [DataWidth-1:0]                a_data;
    logic                                a_corrupt;

    logic                                b_valid, b_ready;
    logic [2:0]                          b_opcode;
    logic [1:0]                          b_param;
    logic [Sw-1:0]                       b_size;
    logic [SourceWidth-1:0]              b_source;
    logic [AddrWidth-1:0]                b_address;
    logic [DataWidth/8-1:0]              b_mask;
    logic [DataWidth-1:0]                b_data;
    logic                                b_corrupt;

    logic                                c_valid, c_ready;
    tl_inflight_limiter_pkg::tl_c_op_e   c_opcode;
    logic [2:0]                          c_param;
    logic [Sw-1:0]                       c_size;
    logic [SourceWidth-1:0]              c_source;
    logic [AddrWidth-1:0]                c_address;
    logic [DataWidth-1:0]                c_data;
    logic                                c_corrupt;

    logic                                d_valid, d_ready;
    tl_inflight_limiter_pkg::tl_d_op_e   d_opcode;
    logic [1:0]                          d_param;
    logic [Sw-1:0]                       d_size;
    logic [SourceWidth-1:0]              d_source;
    logic [SinkWidth-1:0]                d_sink;
    logic                                d_denied;
    logic [DataWidth-1:0]                d_data;
    logic                                d_corrupt;

    logic                                e_valid, e_ready;
    logic [SinkWidth-1:0]                e_sink;

    modport master (
        output a_valid, a_opcode, a_param, a_size, a_source, a_address, a_mask, a_data, a_corrupt,
        input  a_ready,
        input  b_valid, b_opcode, b_param, b_size, b_source, b_address, b_mask, b_data, b_corrupt,
        output b_ready,
        output c_valid, c_opcode, c_param, c_size, c_source, c_address, c_data, c_corrupt,
        input  c_ready,
        input  d_valid, d_opcode, d_param, d_size, d_source, d_sink, d_denied, d_data, d_corrupt,
        output d_ready,
        output e_valid, e_sink,
        input  e_ready
    );

    modport slave (
        input  a_valid, a_opcode, a_param, a_size, a_source, a_address, a_mask, a_data, a_corrupt,
        output a_ready,
        output b_valid, b_opcode, b_param, b_size, b_source, b_address, b_mask, b_data, b_corrupt,
        input  b_ready,
        input  c_valid, c_opcode, c_param, c_size, c_source, c_address, c_data, c_corrupt,
        output c_ready,
        output d_valid, d_opcode, d_param, d_size, d_source, d_sink, d_denied, d_data, d_corrupt,
        input  d_ready,
        input  e_valid, e_sink,
        output e_ready
    );

endinterface

// File: rtl/tl_inflight_limiter_burst_tracker.sv
// Per-channel beat counter: flags the first and last beat of every message
// from opcode payload-ness and size.
module tl_burst_tracker
    import tl_inflight_limiter_pkg::*;
#(
    parameter int DataWidth = 64,
    parameter int MaxSize   = 6,
    parameter int NCh       = NumCh
) (
    input  logic                           clk_i,
    input  logic                           rst_ni,
    input  logic [NCh-1:0]                 fire_i,
    input  logic [NCh-1:0]                 has_data_i,
    input  logic [NCh-1:0][SizeWidth-1:0]  size_i,
    output logic [NCh-1:0]                 first_o,
    output logic [NCh-1:0]                 last_o
);
    localparam int LogBeatBytes = $clog2(DataWidth / 8);
    localparam int BeatWidth    = (MaxSize > LogBeatBytes) ? MaxSize - LogBeatBytes : 1;

    for (genvar i = 0; i < NCh; i++) begin : g_ch
        // remain_q counts beats still owed after the last accepted one; zero means idle
        logic [BeatWidth-1:0] remain_q;
        logic [BeatWidth-1:0] len_m1;

        always_comb begin
            len_m1 = '0;
            if (has_data_i[i] && int'(size_i[i]) > LogBeatBytes)
                len_m1 = BeatWidth'((1 << (int'(size_i[i]) - LogBeatBytes)) - 1);
        end

        assign first_o[i] = (remain_q == '0);
        assign last_o[i]  = first_o[i] ? (len_m1 == '0) : (remain_q == BeatWidth'(1));

        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni)        remain_q <= '0;
            else if (fire_i[i]) remain_q <= first_o[i] ? len_m1 : remain_q - 1'b1;
        end
    end

endmodule

// File: rtl/tl_inflight_limiter.sv
// Caps outstanding A messages and C Releases on a device link; first beats
// stall at the limit, everything else is a zero-latency wire-through.
module tl_inflight_limiter
    import tl_inflight_limiter_pkg::*;
#(
    parameter int DataWidth      = 64,
    parameter int AddrWidth      = 56,
    parameter int SourceWidth    = 1,
    parameter int SinkWidth      = 1,
    parameter int MaxSize        = 6,
    parameter int MaxReqInflight = 2,
    parameter int MaxRelInflight = 1,
    localparam int ACntWidth     = $clog2(MaxReqInflight + 1),
    localparam int CCntWidth     = $clog2(MaxRelInflight + 1)
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    tl_inflight_limiter_if.slave  host,
    tl_inflight_limiter_if.master device,
    output logic [ACntWidth-1:0]  a_inflight_o,
    output logic [CCntWidth-1:0]  c_inflight_o,
    output logic                  idle_o
);
    logic [NumCh-1:0]                trk_fire, trk_has_data, trk_first, trk_last;
    logic [NumCh-1:0][SizeWidth-1:0] trk_size;
    logic [ACntWidth-1:0]            a_cnt_q;
    logic [CCntWidth-1:0]            c_cnt_q;
    logic a_block, c_block, c_is_rel;
    logic a_fire, c_fire, d_fire;
    logic a_inc, a_dec, c_inc, c_dec;
    logic unused_trk;

    assign trk_fire[ChA]     = a_fire;
    assign trk_fire[ChC]     = c_fire;
    assign trk_fire[ChD]     = d_fire;
    assign trk_has_data[ChA] = a_has_data(host.a_opcode);
    assign trk_has_data[ChC] = c_has_data(host.c_opcode);
    assign trk_has_data[ChD] = d_has_data(device.d_opcode);
    assign trk_size[ChA]     = host.a_size;
    assign trk_size[ChC]     = host.c_size;
    assign trk_size[ChD]     = device.d_size;
    assign unused_trk        = ^{trk_last[ChA], trk_last[ChC], trk_first[ChD]};

    tl_burst_tracker #(
        .DataWidth (DataWidth),
        .MaxSize   (MaxSize),
        .NCh       (NumCh)
    ) u_burst_tracker (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .fire_i     (trk_fire),
        .has_data_i (trk_has_data),
        .size_i     (trk_size),
        .first_o    (trk_first),
        .last_o     (trk_last)
    );

    // Admission looks only at registered counts, keeping D off the A/C ready path
    assign a_block  = trk_first[ChA] && (a_cnt_q == ACntWidth'(MaxReqInflight));
    assign c_is_rel = host.c_opcode inside {Release, ReleaseData};
    assign c_block  = trk_first[ChC] && c_is_rel && (c_cnt_q == CCntWidth'(MaxRelInflight));

    assign device.a_valid = host.a_valid && !a_block;
    assign host.a_ready   = device.a_ready && !a_block;
    assign device.c_valid = host.c_valid && !c_block;
    assign host.c_ready   = device.c_ready && !c_block;

    assign a_fire = host.a_valid && host.a_ready;
    assign c_fire = host.c_valid && host.c_ready;
    assign d_fire = device.d_valid && host.d_ready;

    assign a_inc = a_fire && trk_first[ChA];
    assign c_inc = c_fire && trk_first[ChC] && c_is_rel;
    assign a_dec = d_fire && trk_last[ChD] && (device.d_opcode != ReleaseAck);
    assign c_dec = d_fire && (device.d_opcode == ReleaseAck);

    // A retire at zero is a protocol error; the counter saturates rather than wraps
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            a_cnt_q <= '0;
            c_cnt_q <= '0;
        end else begin
            if (a_inc && !a_dec)                       a_cnt_q <= a_cnt_q + 1'b1;
            else if (a_dec && !a_inc && a_cnt_q != '0) a_cnt_q <= a_cnt_q - 1'b1;
            if (c_inc && !c_dec)                       c_cnt_q <= c_cnt_q + 1'b1;
            else if (c_dec && !c_inc && c_cnt_q != '0) c_cnt_q <= c_cnt_q - 1'b1;
        end
    end

    assign a_inflight_o = a_cnt_q;
    assign c_inflight_o = c_cnt_q;
    assign idle_o       = (a_cnt_q == '0) && (c_cnt_q == '0);

    assign device.a_opcode  = host.a_opcode;
    assign device.a_param   = host.a_param;
    assign device.a_size    = host.a_size;
    assign device.a_source  = host.a_source;
    assign device.a_address = host.a_address;
    assign device.a_mask    = host.a_mask;
    assign device.a_data    = host.a_data;
    assign device.a_corrupt = host.a_corrupt;

    assign host.b_valid     = device.b_valid;
    assign host.b_opcode    = device.b_opcode;
    assign host.b_param     = device.b_param;
    assign host.b_size      = device.b_size;
    assign host.b_source    = device.b_source;
    assign host.b_address   = device.b_address;
    assign host.b_mask      = device.b_mask;
    assign host.b_data      = device.b_data;
    assign host.b_corrupt   = device.b_corrupt;
    assign device.b_ready   = host.b_ready;

    assign device.c_opcode  = host.c_opcode;
    assign device.c_param   = host.c_param;
    assign device.c_size    = host.c_size;
    assign device.c_source  = host.c_source;
    assign device.c_address = host.c_address;
    assign device.c_data    = host.c_data;
    assign device.c_corrupt = host.c_corrupt;

    assign host.d_valid     = device.d_valid;
    assign host.d_opcode    = device.d_opcode;
    assign host.d_param     = device.d_param;
    assign host.d_size      = device.d_size;
    assign host.d_source    = device.d_source;
    assign host.d_sink      = device.d_sink;
    assign host.d_denied    = device.d_denied;
    assign host.d_data      = device.d_data;
    assign host.d_corrupt   = device.d_corrupt;
    assign device.d_ready   = host.d_ready;

    assign device.e_valid   = host.e_valid;
    assign device.e_sink    = host.e_sink;
    assign host.e_ready     = device.e_ready;

    a_underflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(a_dec && !a_inc && a_cnt_q == '0));
    c_underflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(c_dec && !c_inc && c_cnt_q == '0));
    link_widths: assert property (@(posedge clk_i)
        $bits(host.a_address) == AddrWidth && $bits(host.a_source) == SourceWidth &&
        $bits(host.d_sink) == SinkWidth && $bits(host.a_data) == DataWidth);

endmodule
